dtcm_ctrl: RTL and testbench

Responder side of the LSU-to-DTCM command/response interface. It accepts `lsu2dtcm_cmd_*` commands from the core and owns a single-port data SRAM array with byte-masked writes. It returns exactly one response per accepted command, in order, with a 2-entry response buffer so the LSU may back-pressure without losing data. It sits at SoC level between `core` and nothing else: it is the DTCM.

---
 rtl/dtcm_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_dtcm_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dtcm_ctrl.sv
// DTCM responder: single-port byte-masked SRAM, one-cycle read pipeline, 2-entry in-order response FIFO.
// Optional DTCM_INIT_ZERO_EN: zero-fill sweep after reset before commands are accepted.
module dtcm_ctrl #(
  parameter int DW = 32,
  parameter int AW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dtcm_cmd_valid,
  output logic            dtcm_cmd_ready,
  input  logic            dtcm_cmd_read,
  input  logic [AW-1:0]   dtcm_cmd_addr,
  input  logic [DW-1:0]   dtcm_cmd_wdata,
  input  logic [DW/8-1:0] dtcm_cmd_wmask,
  output logic            dtcm_rsp_valid,
  input  logic            dtcm_rsp_ready,
  output logic [DW-1:0]   dtcm_rsp_rdata,
  output logic            dtcm_init_done
);

  localparam int NB    = DW / 8;
  localparam int IW    = AW - 2;
  localparam int DEPTH = 1 << IW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] sram_q;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_read_q, s1_read_d;
  logic [DW-1:0] fifo_q [2];
  logic [DW-1:0] fifo_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          init_done_q, init_done_d;

  logic          cmd_ready_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic [DW-1:0] s1_data_s;
  logic          mem_we_s;
  logic          mem_re_s;
  logic [IW-1:0] mem_idx_s;
  logic [DW-1:0] mem_wdata_s;
  logic [NB-1:0] mem_wmask_s;
  logic          unused_s;

  assign unused_s = ^dtcm_cmd_addr[1:0];

  // Occupancy counts both the FIFO and the result still sitting in S1, so the FIFO cannot overflow.
  assign cmd_ready_s = ~rst & init_done_q &
                       (({1'b0, count_q} + {2'b00, s1_valid_q}) < 3'd2);
  assign accept_s    = dtcm_cmd_valid & cmd_ready_s;
  assign push_s      = s1_valid_q & ~((count_q == 2'd0) & dtcm_rsp_ready);
  assign pop_s       = (count_q != 2'd0) & dtcm_rsp_ready;
  assign s1_data_s   = s1_read_q ? sram_q : {DW{1'b0}};

  assign dtcm_cmd_ready = cmd_ready_s;
  assign dtcm_rsp_valid = (count_q != 2'd0) | s1_valid_q;
  assign dtcm_rsp_rdata = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : s1_data_s;
  assign dtcm_init_done = init_done_q;

  always_comb begin
    s1_valid_d = accept_s;
    s1_read_d  = accept_s & dtcm_cmd_read;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push_s) begin
      fifo_d[wr_ptr_q] = s1_data_s;
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_read_q  <= 1'b0;
      fifo_q[0]  <= {DW{1'b0}};
      fifo_q[1]  <= {DW{1'b0}};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_read_q  <= s1_read_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

`ifdef DTCM_INIT_ZERO_EN
  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] sweep_q, sweep_d;

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + IW'(1);
        if (&sweep_q) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          state_d     = ST_INIT;
          init_done_d = 1'b0;
        end
      end
      ST_RUN: begin
        init_done_d = 1'b1;
      end
      default: begin
        state_d     = ST_INIT;
        sweep_d     = {IW{1'b0}};
        init_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      sweep_q     <= {IW{1'b0}};
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= init_done_d;
    end
  end

  // The sweep borrows the single array port; commands are blocked until it finishes.
  always_comb begin
    mem_we_s    = accept_s & ~dtcm_cmd_read;
    mem_re_s    = accept_s & dtcm_cmd_read;
    mem_idx_s   = dtcm_cmd_addr[AW-1:2];
    mem_wdata_s = dtcm_cmd_wdata;
    mem_wmask_s = dtcm_cmd_wmask;
    if ((state_q == ST_INIT) && !rst) begin
      mem_we_s    = 1'b1;
      mem_idx_s   = sweep_q;
      mem_wdata_s = {DW{1'b0}};
      mem_wmask_s = {NB{1'b1}};
    end else begin
      mem_we_s    = accept_s & ~dtcm_cmd_read;
    end
  end
`else
  always_comb begin
    init_done_d = 1'b1;
    mem_we_s    = accept_s & ~dtcm_cmd_read;
    mem_re_s    = accept_s & dtcm_cmd_read;
    mem_idx_s   = dtcm_cmd_addr[AW-1:2];
    mem_wdata_s = dtcm_cmd_wdata;
    mem_wmask_s = dtcm_cmd_wmask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= init_done_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_wmask_s[i]) begin
          mem[mem_idx_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
        end
      end
    end
  end

  // Read data is held until the next accepted read so a stalled S1 result stays valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_q <= {DW{1'b0}};
    end else if (mem_re_s) begin
      sram_q <= mem[mem_idx_s];
    end
  end

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Directed self-checking bench for dtcm_ctrl (AW = 16); expectations adapt to DTCM_INIT_ZERO_EN.
module tb_dtcm_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 1 << (AW - 2);
`ifdef DTCM_INIT_ZERO_EN
  localparam int          EXP_INIT_LAT = DEPTH;
  localparam logic [31:0] EXP_KEEP_10  = 32'h0000_0000;
  localparam logic [31:0] EXP_KEEP_20  = 32'h0000_0000;
`else
  localparam int          EXP_INIT_LAT = 1;
  localparam logic [31:0] EXP_KEEP_10  = 32'hDEAD_BEEF;
  localparam logic [31:0] EXP_KEEP_20  = 32'h11BB_33DD;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dtcm_cmd_valid = 1'b0;
  logic          dtcm_cmd_ready;
  logic          dtcm_cmd_read = 1'b0;
  logic [AW-1:0] dtcm_cmd_addr = '0;
  logic [DW-1:0] dtcm_cmd_wdata = '0;
  logic [3:0]    dtcm_cmd_wmask = '0;
  logic          dtcm_rsp_valid;
  logic          dtcm_rsp_ready = 1'b1;
  logic [DW-1:0] dtcm_rsp_rdata;
  logic          dtcm_init_done;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic          collect  = 1'b0;
  logic [31:0]   rsp_q [$];
  logic [31:0]   exp_bp [4];

  dtcm_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .dtcm_cmd_valid (dtcm_cmd_valid),
    .dtcm_cmd_ready (dtcm_cmd_ready),
    .dtcm_cmd_read  (dtcm_cmd_read),
    .dtcm_cmd_addr  (dtcm_cmd_addr),
    .dtcm_cmd_wdata (dtcm_cmd_wdata),
    .dtcm_cmd_wmask (dtcm_cmd_wmask),
    .dtcm_rsp_valid (dtcm_rsp_valid),
    .dtcm_rsp_ready (dtcm_rsp_ready),
    .dtcm_rsp_rdata (dtcm_rsp_rdata),
    .dtcm_init_done (dtcm_init_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (collect && dtcm_rsp_valid && dtcm_rsp_ready) begin
      rsp_q.push_back(dtcm_rsp_rdata);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic rd, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] m);
    dtcm_cmd_valid = 1'b1;
    dtcm_cmd_read  = rd;
    dtcm_cmd_addr  = a;
    dtcm_cmd_wdata = d;
    dtcm_cmd_wmask = m;
  endtask

  // Waits (bounded) for ready, lets the next rising edge accept, then drops valid.
  task automatic accept_cmd(input string tag);
    int i;
    for (i = 0; i < 50 && !dtcm_cmd_ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!dtcm_cmd_ready) begin
      check_val({tag, "_ready_timeout"}, {31'b0, dtcm_cmd_ready}, 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    dtcm_cmd_valid = 1'b0;
  endtask

  task automatic wait_init(input string tag, output int waited);
    waited = 0;
    while (!dtcm_init_done && waited < 20000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_val(tag, {31'b0, dtcm_init_done}, 32'd1);
  endtask

  initial begin
    int lat;
    exp_bp[0] = 32'h0000_000A;
    exp_bp[1] = 32'h0000_000B;
    exp_bp[2] = 32'h0000_000C;
    exp_bp[3] = 32'h0000_000D;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_cmd_ready", {31'b0, dtcm_cmd_ready}, 32'd0);
    check_val("rst_rsp_valid", {31'b0, dtcm_rsp_valid}, 32'd0);
    check_val("rst_rsp_rdata", dtcm_rsp_rdata, 32'd0);
    check_val("rst_init_done", {31'b0, dtcm_init_done}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_init("init_done", lat);
    check_val("init_latency", lat, EXP_INIT_LAT);

    // Write then read
    drive_cmd(1'b0, 16'h0010, 32'hDEAD_BEEF, 4'hF);
    accept_cmd("wr1");
    @(negedge clk);
    check_val("wr1_rsp_valid", {31'b0, dtcm_rsp_valid}, 32'd1);
    check_val("wr1_rsp_rdata", dtcm_rsp_rdata, 32'd0);
    drive_cmd(1'b1, 16'h0010, 32'd0, 4'h0);
    accept_cmd("rd1");
    @(negedge clk);
    check_val("rd1_rsp_valid", {31'b0, dtcm_rsp_valid}, 32'd1);
    check_val("rd1_rsp_rdata", dtcm_rsp_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check_val("rd1_no_dup", {31'b0, dtcm_rsp_valid}, 32'd0);

    // Byte mask
    drive_cmd(1'b0, 16'h0020, 32'h1122_3344, 4'hF);
    accept_cmd("wr_full");
    drive_cmd(1'b0, 16'h0020, 32'hAABB_CCDD, 4'h5);
    accept_cmd("wr_mask");
    drive_cmd(1'b1, 16'h0020, 32'd0, 4'h0);
    accept_cmd("rd_mask");
    @(negedge clk);
    check_val("mask_rdata", dtcm_rsp_rdata, 32'h11BB_33DD);

    // Back-to-back read-after-write
    @(posedge clk);
    #1;
    drive_cmd(1'b0, 16'h0100, 32'h0000_0005, 4'hF);
    @(negedge clk);
    check_val("raw_ready_wr", {31'b0, dtcm_cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    drive_cmd(1'b1, 16'h0100, 32'd0, 4'h0);
    @(negedge clk);
    check_val("raw_ready_rd", {31'b0, dtcm_cmd_ready}, 32'd1);
    check_val("raw_wr_rdata", dtcm_rsp_rdata, 32'd0);
    @(posedge clk);
    #1;
    dtcm_cmd_valid = 1'b0;
    @(negedge clk);
    check_val("raw_rd_valid", {31'b0, dtcm_rsp_valid}, 32'd1);
    check_val("raw_rd_rdata", dtcm_rsp_rdata, 32'h0000_0005);

    // Back-pressure
    for (int i = 0; i < 4; i++) begin
      drive_cmd(1'b0, AW'(4 * i), exp_bp[i], 4'hF);
      accept_cmd("bp_preload");
    end
    @(posedge clk);
    #1;
    rsp_q.delete();
    collect        = 1'b1;
    dtcm_rsp_ready = 1'b0;
    drive_cmd(1'b1, 16'h0000, 32'd0, 4'h0);
    accept_cmd("bp_rd0");
    drive_cmd(1'b1, 16'h0004, 32'd0, 4'h0);
    accept_cmd("bp_rd4");
    drive_cmd(1'b1, 16'h0008, 32'd0, 4'h0);
    repeat (3) begin
      @(negedge clk);
      check_val("bp_ready_low", {31'b0, dtcm_cmd_ready}, 32'd0);
      check_val("bp_hold_valid", {31'b0, dtcm_rsp_valid}, 32'd1);
      check_val("bp_hold_rdata", dtcm_rsp_rdata, 32'h0000_000A);
    end
    @(posedge clk);
    #1;
    dtcm_rsp_ready = 1'b1;
    accept_cmd("bp_rd8");
    drive_cmd(1'b1, 16'h000C, 32'd0, 4'h0);
    accept_cmd("bp_rd12");
    repeat (4) @(posedge clk);
    #1;
    collect = 1'b0;
    check_val("bp_count", rsp_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val("bp_order", (i < rsp_q.size()) ? rsp_q[i] : 32'hXXXX_XXXX, exp_bp[i]);
    end

    // Reset with two responses buffered
    dtcm_rsp_ready = 1'b0;
    drive_cmd(1'b1, 16'h0010, 32'd0, 4'h0);
    accept_cmd("mr_rd10");
    drive_cmd(1'b1, 16'h0020, 32'd0, 4'h0);
    accept_cmd("mr_rd20");
    @(negedge clk);
    check_val("mr_pre_valid", {31'b0, dtcm_rsp_valid}, 32'd1);
    check_val("mr_pre_rdata", dtcm_rsp_rdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("mr_ready_in_rst", {31'b0, dtcm_cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("mr_rsp_valid", {31'b0, dtcm_rsp_valid}, 32'd0);
    check_val("mr_rsp_rdata", dtcm_rsp_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    dtcm_rsp_ready = 1'b1;
    wait_init("mr_init_done", lat);
    check_val("mr_init_latency", lat, EXP_INIT_LAT);
    drive_cmd(1'b1, 16'h0010, 32'd0, 4'h0);
    accept_cmd("mr_rd_after");
    @(negedge clk);
    check_val("mr_keep_10", dtcm_rsp_rdata, EXP_KEEP_10);
    drive_cmd(1'b1, 16'h0020, 32'd0, 4'h0);
    accept_cmd("mr_rd_after2");
    @(negedge clk);
    check_val("mr_keep_20", dtcm_rsp_rdata, EXP_KEEP_20);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
